// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC and drives instruction fetch.
// There is one outstanding memory request at a time and a one-entry output
// slot toward decode. Branch-unit redirects flush in-flight fetches, and a
// misaligned redirect target halts fetch until the next reset.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_instr,
  output logic             instr_valid,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  input  logic             stall,
  input  logic             br_resolve,
  input  logic             take_branch,
  input  logic             jump,
  input  logic [31:0]      pc_target,
  output logic             trap_misaligned,
  output logic [31:0]      trap_pc,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic             kill_reg, kill_next;
  logic             instr_valid_reg, instr_valid_next;
  logic [31:0]      instr_reg, instr_next;
  logic [31:0]      instr_pc_reg, instr_pc_next;
  logic             trap_reg, trap_next;
  logic [31:0]      trap_pc_reg, trap_pc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic redirect;
  logic misalign;
  logic consume;
  logic slot_free;
  logic accept;

  assign redirect  = br_resolve & (take_branch | jump);
  assign misalign  = redirect & (pc_target[1:0] != 2'b00);
  assign consume   = instr_valid_reg & ~stall;
  assign slot_free = ~instr_valid_reg | consume;

  // A request is only offered when its instruction will have a free slot.
  assign imem_req_valid = (state_reg == ST_REQ) & slot_free;
  assign imem_req_addr  = {pc_reg[31:2], 2'b00};
  assign accept         = imem_req_valid & imem_req_ready;

  assign instr_valid     = instr_valid_reg;
  assign instr           = instr_reg;
  assign instr_pc        = instr_pc_reg;
  assign trap_misaligned = trap_reg;
  assign trap_pc         = trap_pc_reg;
  assign redirect_cnt    = cnt_reg;

  // Next-state: normal fetch flow first, then redirects override it.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    kill_next        = kill_reg;
    instr_valid_next = instr_valid_reg;
    instr_next       = instr_reg;
    instr_pc_next    = instr_pc_reg;
    trap_next        = trap_reg;
    trap_pc_next     = trap_pc_reg;
    cnt_next         = cnt_reg;

    if (consume) begin
      instr_valid_next = 1'b0;
    end

    case (state_reg)
      ST_BOOT: state_next = ST_REQ;
      ST_REQ: begin
        if (accept) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_next = ST_REQ;
          if (kill_reg) begin
            // Response belongs to a flushed request: drop it.
            kill_next = 1'b0;
          end else begin
            instr_valid_next = 1'b1;
            instr_next       = imem_rsp_instr;
            instr_pc_next    = pc_reg;
            pc_next          = pc_reg + 32'd4;
          end
        end
      end
      default: ;
    endcase

    // Once halted only reset gets us out, so redirects are ignored there.
    if (state_reg != ST_HALT) begin
      if (misalign) begin
        trap_next        = 1'b1;
        trap_pc_next     = pc_target;
        instr_valid_next = 1'b0;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        pc_next          = pc_reg;
        kill_next        = 1'b0;
        state_next       = ST_HALT;
      end else if (redirect) begin
        pc_next          = pc_target;
        instr_valid_next = 1'b0;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        cnt_next         = cnt_reg + CNT_ONE;
        kill_next        = 1'b0;
        state_next       = ST_REQ;
        // A request still in flight (or accepted right now) must be killed.
        if ((state_reg == ST_WAIT && !imem_rsp_valid) ||
            (state_reg == ST_REQ && accept)) begin
          kill_next  = 1'b1;
          state_next = ST_WAIT;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_BOOT;
      pc_reg          <= RESET_PC;
      kill_reg        <= 1'b0;
      instr_valid_reg <= 1'b0;
      instr_reg       <= 32'd0;
      instr_pc_reg    <= 32'd0;
      trap_reg        <= 1'b0;
      trap_pc_reg     <= 32'd0;
      cnt_reg         <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      kill_reg        <= kill_next;
      instr_valid_reg <= instr_valid_next;
      instr_reg       <= instr_next;
      instr_pc_reg    <= instr_pc_next;
      trap_reg        <= trap_next;
      trap_pc_reg     <= trap_pc_next;
      cnt_reg         <= cnt_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: memory models return addr^MAGIC as the instruction;
// each test pushes the PCs it expects decode to see and pops them on consume.
module tb_pc_sequencer;

  localparam logic [31:0] MAGIC = 32'hC0DE_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_instr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        stall;
  logic        br_resolve;
  logic        take_branch;
  logic        jump;
  logic [31:0] pc_target;
  logic        trap_misaligned;
  logic [31:0] trap_pc;
  logic [15:0] redirect_cnt;

  logic        req_valid2;
  logic [31:0] req_addr2;
  logic        rsp_valid2;
  logic [31:0] rsp_instr2;
  logic        instr_valid2;
  logic [31:0] instr2;
  logic [31:0] instr_pc2;
  logic        trap2;
  logic [31:0] trap_pc2;
  logic [15:0] cnt2;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_q2[$];
  int          mem_lat = 1;
  logic        inject = 1'b0;
  logic [31:0] inject_instr = 32'd0;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_instr(imem_rsp_instr), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .stall(stall),
    .br_resolve(br_resolve), .take_branch(take_branch), .jump(jump),
    .pc_target(pc_target), .trap_misaligned(trap_misaligned),
    .trap_pc(trap_pc), .redirect_cnt(redirect_cnt)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid2), .imem_req_addr(req_addr2),
    .imem_req_ready(1'b1), .imem_rsp_valid(rsp_valid2),
    .imem_rsp_instr(rsp_instr2), .instr_valid(instr_valid2),
    .instr(instr2), .instr_pc(instr_pc2), .stall(1'b0),
    .br_resolve(1'b0), .take_branch(1'b0), .jump(1'b0),
    .pc_target(32'd0), .trap_misaligned(trap2),
    .trap_pc(trap_pc2), .redirect_cnt(cnt2)
  );

  // Memory for the main DUT: one outstanding request, mem_lat cycles latency.
  initial begin : mem_main
    logic        acc;
    logic        pend;
    logic [31:0] a;
    logic [31:0] paddr;
    int          cnt;
    pend = 1'b0; paddr = 32'd0; cnt = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_instr = 32'd0;
    forever begin
      @(negedge clk);
      #4;
      acc = imem_req_valid && imem_req_ready;
      a   = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (!rst_n) pend = 1'b0;
      else if (acc) begin
        pend = 1'b1; cnt = mem_lat; paddr = a;
      end
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          pend = 1'b0;
          imem_rsp_valid = 1'b1;
          imem_rsp_instr = paddr ^ MAGIC;
        end
      end
      if (inject) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_instr = inject_instr;
      end
    end
  end

  // Memory for the wrap DUT: always ready, one-cycle latency.
  initial begin : mem_wrap
    logic        acc;
    logic [31:0] a;
    rsp_valid2 = 1'b0;
    rsp_instr2 = 32'd0;
    forever begin
      @(negedge clk);
      #4;
      acc = req_valid2;
      a   = req_addr2;
      @(posedge clk);
      #1;
      rsp_valid2 = acc && rst_n;
      rsp_instr2 = a ^ MAGIC;
    end
  end

  task automatic do_reset(input int lat);
    @(negedge clk);
    rst_n = 1'b0;
    imem_req_ready = 1'b1; stall = 1'b0;
    br_resolve = 1'b0; take_branch = 1'b0; jump = 1'b0; pc_target = 32'd0;
    mem_lat = lat;
    exp_q.delete();
    exp_q2.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({instr_valid, imem_req_valid, trap_misaligned} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: valid/req/trap=%b required 000", {instr_valid, imem_req_valid, trap_misaligned});
    end
    checks++;
    if ({instr, instr_pc, trap_pc} !== 96'd0 || redirect_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_values: instr=%h pc=%h trap_pc=%h cnt=%0d required all 0", instr, instr_pc, trap_pc, redirect_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL boot_idle: imem_req_valid=%b required 0", imem_req_valid);
    end
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd0) begin
      errors++; $display("FAIL first_req: valid=%b addr=%h required 1/00000000", imem_req_valid, imem_req_addr);
    end
    $display("test_reset done");
  endtask

  task automatic test_seq_fetch;
    logic [31:0] e;
    int first_cyc, last_cyc;
    do_reset(1);
    // Unqualified branch inputs must be ignored.
    take_branch = 1'b1; jump = 1'b1; pc_target = 32'h300;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    first_cyc = -1; last_cyc = -1;
    for (int cyc = 1; cyc < 40 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (instr_valid && first_cyc < 0) first_cyc = cyc;
      if (imem_req_valid && imem_req_addr[1:0] != 2'b00) begin
        checks++; errors++; $display("FAIL seq_align: addr=%h required low bits 00", imem_req_addr);
      end
      if (instr_valid && !stall) begin
        e = exp_q.pop_front();
        last_cyc = cyc;
        checks++;
        if (instr_pc !== e || instr !== (e ^ MAGIC)) begin
          errors++; $display("FAIL seq_pop: pc=%h instr=%h required pc=%h instr=%h", instr_pc, instr, e, e ^ MAGIC);
        end
        $display("seq consume pc=%h instr=%h at cycle %0d", instr_pc, instr, cyc);
      end
    end
    take_branch = 1'b0; jump = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL seq_timeout: %0d pending required 0", exp_q.size());
    end
    checks++;
    if (first_cyc != 3 || last_cyc != 7) begin
      errors++; $display("FAIL seq_timing: first=%0d last=%0d required 3/7", first_cyc, last_cyc);
    end
  endtask

  task automatic test_stall;
    logic [31:0] e;
    int n;
    do_reset(1);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    n = 0;
    do begin @(negedge clk); n++; end while (!instr_valid && n < 20);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== MAGIC || imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL stall_hold: valid=%b pc=%h instr=%h req=%b required 1/0/%h/0", instr_valid, instr_pc, instr, imem_req_valid, MAGIC);
      end
    end
    stall = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
      errors++; $display("FAIL stall_release_req: valid=%b addr=%h required 1/00000004", imem_req_valid, imem_req_addr);
    end
    for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (instr_valid && !stall) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_pc !== e || instr !== (e ^ MAGIC)) begin
          errors++; $display("FAIL stall_pop: pc=%h instr=%h required pc=%h", instr_pc, instr, e);
        end
        $display("stall consume pc=%h", instr_pc);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL stall_timeout: %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_wait;
    logic [31:0] e;
    logic fire, done;
    do_reset(3);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    fire = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (instr_valid && !stall) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_pc !== e || instr !== (e ^ MAGIC)) begin
          errors++; $display("FAIL rwait_pop: pc=%h instr=%h required pc=%h", instr_pc, instr, e);
        end
        $display("rwait consume pc=%h", instr_pc);
      end
      br_resolve = 1'b0; take_branch = 1'b0;
      if (fire) begin
        br_resolve = 1'b1; take_branch = 1'b1; pc_target = 32'h100; fire = 1'b0;
      end
      if (!done && imem_req_valid && imem_req_ready && imem_req_addr == 32'h8) begin
        fire = 1'b1; done = 1'b1;
      end
    end
    br_resolve = 1'b0; take_branch = 1'b0;
    checks++;
    if (exp_q.size() != 0 || !done) begin
      errors++; $display("FAIL rwait_timeout: %0d pending, trigger=%b required 0/1", exp_q.size(), done);
    end
    checks++;
    if (redirect_cnt !== 16'd1) begin
      errors++; $display("FAIL rwait_cnt: redirect_cnt=%0d required 1", redirect_cnt);
    end
  endtask

  task automatic test_redirect_coincident;
    logic [31:0] e;
    logic fire, done;
    for (int mode = 0; mode < 2; mode++) begin
      do_reset(1);
      exp_q.push_back(32'h0); exp_q.push_back(32'h200); exp_q.push_back(32'h204);
      fire = 1'b0; done = 1'b0;
      for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
        @(negedge clk);
        if (instr_valid && !stall) begin
          e = exp_q.pop_front();
          checks++;
          if (instr_pc !== e || instr !== (e ^ MAGIC)) begin
            errors++; $display("FAIL coinc_pop: mode=%0d pc=%h instr=%h required pc=%h", mode, instr_pc, instr, e);
          end
          $display("coinc mode=%0d consume pc=%h", mode, instr_pc);
        end
        br_resolve = 1'b0; jump = 1'b0;
        if (fire) begin
          checks++;
          if (imem_rsp_valid !== 1'b1) begin
            errors++; $display("FAIL coinc_rsp_setup: rsp_valid=%b required 1", imem_rsp_valid);
          end
          br_resolve = 1'b1; jump = 1'b1; pc_target = 32'h200; fire = 1'b0;
        end
        if (!done && imem_req_valid && imem_req_ready && imem_req_addr == 32'h4) begin
          done = 1'b1;
          if (mode == 0) begin
            br_resolve = 1'b1; jump = 1'b1; pc_target = 32'h200;
          end else begin
            fire = 1'b1;
          end
        end
      end
      br_resolve = 1'b0; jump = 1'b0;
      checks++;
      if (exp_q.size() != 0 || !done) begin
        errors++; $display("FAIL coinc_timeout: mode=%0d %0d pending, trigger=%b", mode, exp_q.size(), done);
      end
      checks++;
      if (redirect_cnt !== 16'd1) begin
        errors++; $display("FAIL coinc_cnt: mode=%0d redirect_cnt=%0d required 1", mode, redirect_cnt);
      end
    end
  endtask

  task automatic test_misaligned;
    logic [31:0] e;
    logic done;
    do_reset(1);
    exp_q.push_back(32'h0);
    done = 1'b0;
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      @(negedge clk);
      if (instr_valid && !stall && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_pc !== e) begin
          errors++; $display("FAIL mis_pop: pc=%h required %h", instr_pc, e);
        end
      end
      if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h4) done = 1'b1;
    end
    @(negedge clk);
    br_resolve = 1'b1; jump = 1'b1; pc_target = 32'h102;
    @(negedge clk);
    br_resolve = 1'b0; jump = 1'b0;
    checks++;
    if (trap_misaligned !== 1'b1 || trap_pc !== 32'h102) begin
      errors++; $display("FAIL mis_trap: trap=%b trap_pc=%h required 1/00000102", trap_misaligned, trap_pc);
    end
    checks++;
    if (redirect_cnt !== 16'd0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL mis_state: cnt=%0d valid=%b required 0/0", redirect_cnt, instr_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || trap_misaligned !== 1'b1) begin
        errors++; $display("FAIL mis_halt: req=%b valid=%b trap=%b required 0/0/1", imem_req_valid, instr_valid, trap_misaligned);
      end
    end
    $display("misaligned trap_pc=%h", trap_pc);
  endtask

  task automatic test_wrap;
    logic [31:0] e;
    do_reset(1);
    exp_q2.push_back(32'hFFFF_FFFC); exp_q2.push_back(32'h0); exp_q2.push_back(32'h4);
    for (int cyc = 0; cyc < 40 && exp_q2.size() > 0; cyc++) begin
      @(negedge clk);
      if (instr_valid2) begin
        e = exp_q2.pop_front();
        checks++;
        if (instr_pc2 !== e || instr2 !== (e ^ MAGIC)) begin
          errors++; $display("FAIL wrap_pop: pc=%h instr=%h required pc=%h", instr_pc2, instr2, e);
        end
        $display("wrap consume pc=%h", instr_pc2);
      end
    end
    checks++;
    if (exp_q2.size() != 0 || trap2 !== 1'b0 || trap_pc2 !== 32'd0 || cnt2 !== 16'd0) begin
      errors++; $display("FAIL wrap_end: pending=%0d trap=%b trap_pc=%h cnt=%0d required 0/0/0/0", exp_q2.size(), trap2, trap_pc2, cnt2);
    end
  endtask

  task automatic test_reset_mid_fetch;
    logic [31:0] e;
    logic done;
    do_reset(3);
    // Redirect while still in BOOT.
    br_resolve = 1'b1; jump = 1'b1; pc_target = 32'h40;
    exp_q.push_back(32'h40);
    done = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      br_resolve = 1'b0; jump = 1'b0;
      if (instr_valid && !stall && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_pc !== e || instr !== (e ^ MAGIC)) begin
          errors++; $display("FAIL mid_pop: pc=%h instr=%h required pc=%h", instr_pc, instr, e);
        end
      end
      if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h44) done = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (redirect_cnt !== 16'd1 || instr_pc !== 32'h40 || !done) begin
      errors++; $display("FAIL mid_pre: cnt=%0d pc=%h trigger=%b required 1/00000040/1", redirect_cnt, instr_pc, done);
    end
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    checks++;
    if (redirect_cnt !== 16'd0 || instr_pc !== 32'd0 || instr !== 32'd0 || instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset: cnt=%0d pc=%h instr=%h valid=%b req=%b required all 0", redirect_cnt, instr_pc, instr, instr_valid, imem_req_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    inject = 1'b1; inject_instr = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++; $display("FAIL mid_stale: valid=%b instr=%h required 0", instr_valid, instr);
      end
    end
    inject = 1'b0;
    imem_req_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
      @(negedge clk);
      if (instr_valid && !stall) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_pc !== e || instr !== (e ^ MAGIC)) begin
          errors++; $display("FAIL mid_after: pc=%h instr=%h required pc=%h instr=%h", instr_pc, instr, e, e ^ MAGIC);
        end
        $display("after reset consume pc=%h instr=%h", instr_pc, instr);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL mid_timeout: %0d pending required 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b1; stall = 1'b0;
    br_resolve = 1'b0; take_branch = 1'b0; jump = 1'b0; pc_target = 32'd0;
    test_reset;
    test_seq_fetch;
    test_stall;
    test_redirect_wait;
    test_redirect_coincident;
    test_misaligned;
    test_wrap;
    test_reset_mid_fetch;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
